// File: rtl/trb_mem_ctrl_pkg.sv
// Shared constants and types for the trace-buffer memory stage.
package trb_mem_ctrl_pkg;

  localparam int unsigned TRB_WIDTH         = 8;
  localparam int unsigned TRB_ADDR_WIDTH    = 3;
  localparam int unsigned TRB_DEPTH         = 2 ** TRB_ADDR_WIDTH;
  localparam int unsigned TRB_OVF_CNT_WIDTH = 16;

  // Buffer policy selected by the Logger configuration.
  typedef enum logic {
    TRB_MODE_TRACE  = 1'b0,
    TRB_MODE_STREAM = 1'b1
  } trb_mode_e;

endpackage

// File: rtl/trb_mem_ctrl_if.sv
// Logger <-> trace-buffer port bundle. The master side is the Logger,
// the slave side is trb_mem_ctrl.
interface trb_mem_ctrl_if
  import trb_mem_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH         = TRB_WIDTH,
  parameter int unsigned ADDR_WIDTH    = TRB_ADDR_WIDTH,
  parameter int unsigned OVF_CNT_WIDTH = TRB_OVF_CNT_WIDTH
);

  logic                     CLEAR_I;
  trb_mode_e                MODE_I;
  logic                     RW_TURN_O;
  logic                     WRITE_I;
  logic [ADDR_WIDTH-1:0]    WRITE_PTR_I;
  logic [WIDTH-1:0]         DMEM_I;
  logic                     WRITE_ALLOW_O;
  logic                     READ_I;
  logic [ADDR_WIDTH-1:0]    READ_PTR_I;
  logic [WIDTH-1:0]         DMEM_O;
  logic                     READ_ALLOW_O;
  logic [ADDR_WIDTH:0]      FILL_O;
  logic [OVF_CNT_WIDTH-1:0] OVF_CNT_O;

  modport master (
    output CLEAR_I, MODE_I, WRITE_I, WRITE_PTR_I, DMEM_I, READ_I, READ_PTR_I,
    input  RW_TURN_O, WRITE_ALLOW_O, DMEM_O, READ_ALLOW_O, FILL_O, OVF_CNT_O
  );

  modport slave (
    input  CLEAR_I, MODE_I, WRITE_I, WRITE_PTR_I, DMEM_I, READ_I, READ_PTR_I,
    output RW_TURN_O, WRITE_ALLOW_O, DMEM_O, READ_ALLOW_O, FILL_O, OVF_CNT_O
  );

endinterface

// File: rtl/trb_sdp_ram.sv
// Simple dual-port trace RAM: one write port, one registered read port
// with enable. Array is not reset; only the read register is.
module trb_sdp_ram #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; holds its value while re is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/trb_mem_ctrl.sv
// Trace-buffer memory and arbitration stage downstream of the Logger.
// Alternates read/write slots, owns the trace RAM, tracks occupancy and
// drives the write/read permissions back to the Logger.
// Optional dropped-write counter: define TRB_MEM_OVF_CNT_EN.
module trb_mem_ctrl
  import trb_mem_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH         = TRB_WIDTH,
  parameter int unsigned ADDR_WIDTH    = TRB_ADDR_WIDTH,
  parameter int unsigned OVF_CNT_WIDTH = TRB_OVF_CNT_WIDTH
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  trb_mem_ctrl_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] FILL_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic                  rw_turn;
  logic [ADDR_WIDTH:0]   fill;
  logic                  write_allow;
  logic                  commit;
  logic                  consume;
  logic                  rd_en;
  logic [WIDTH-1:0]      rd_data;

  // Stream mode refuses writes once every slot holds unread data.
  assign write_allow = (bus.MODE_I == TRB_MODE_TRACE) || (fill < DEPTH);
  assign commit      = rw_turn & bus.WRITE_I & write_allow;
  assign consume     = bus.READ_I & (fill != '0);
  assign rd_en       = ~rw_turn;

  // Read/write slot toggle; first edge after reset is a read slot.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rw_turn <= 1'b0;
    end else begin
      rw_turn <= ~rw_turn;
    end
  end

  // Occupancy: clear wins, trace mode saturates at depth (oldest word lost).
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      fill <= '0;
    end else if (bus.CLEAR_I) begin
      fill <= '0;
    end else if (commit && !consume) begin
      if (fill != DEPTH) begin
        fill <= fill + FILL_ONE;
      end
    end else if (consume && !commit) begin
      fill <= fill - FILL_ONE;
    end
  end

  trb_sdp_ram #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (CLK_I),
    .rst   (RST_I),
    .we    (commit),
    .waddr (bus.WRITE_PTR_I),
    .wdata (bus.DMEM_I),
    .re    (rd_en),
    .raddr (bus.READ_PTR_I),
    .rdata (rd_data)
  );

  assign bus.RW_TURN_O     = rw_turn;
  assign bus.WRITE_ALLOW_O = write_allow;
  assign bus.READ_ALLOW_O  = (fill != '0);
  assign bus.FILL_O        = fill;
  assign bus.DMEM_O        = rd_data;

`ifdef TRB_MEM_OVF_CNT_EN
  localparam logic [OVF_CNT_WIDTH-1:0] OVF_ONE = {{(OVF_CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                     drop;
  logic [OVF_CNT_WIDTH-1:0] ovf_cnt;

  assign drop = rw_turn & bus.WRITE_I & ~write_allow;

  // Saturating count of write-slot writes refused for lack of space.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ovf_cnt <= '0;
    end else if (bus.CLEAR_I) begin
      ovf_cnt <= '0;
    end else if (drop && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + OVF_ONE;
    end
  end

  assign bus.OVF_CNT_O = ovf_cnt;
`else
  assign bus.OVF_CNT_O = {OVF_CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_trb_mem_ctrl.sv
// Scoreboard bench for trb_mem_ctrl (depth 8). The driver steps a
// behavioural model each cycle and queues the expected post-edge outputs;
// an independent monitor pops and compares one entry per clock.
module tb_trb_mem_ctrl;
  import trb_mem_ctrl_pkg::*;

  localparam int unsigned W     = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned OW    = 16;
  localparam int          DEPTH = 8;
  localparam int          OVF_MAX = 65535;

  logic CLK_I = 1'b0;
  logic RST_I = 1'b1;

  trb_mem_ctrl_if #(.WIDTH(W), .ADDR_WIDTH(AW), .OVF_CNT_WIDTH(OW)) bus ();

  trb_mem_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW), .OVF_CNT_WIDTH(OW)) dut (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .bus   (bus)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct {
    bit turn;
    int fill;
    bit rallow;
    bit wallow;
    int dmem;
    bit dknown;
    int ovf;
  } exp_t;

  exp_t sbq[$];

  // Reference model state.
  int        m_mem [DEPTH];
  bit        m_kn  [DEPTH];
  int        m_fill;
  int        m_ovf;
  int        m_dmem;
  bit        m_dkn;
  bit        m_turn;
  trb_mode_e cur_md = TRB_MODE_TRACE;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_turn = 1'b0;
    m_fill = 0;
    m_ovf  = 0;
    m_dmem = 0;
    m_dkn  = 1'b1;
  endtask

  // Drive one cycle from a negedge, advance the model, queue expectation,
  // and return at the following negedge (DUT then shows this cycle's result).
  task automatic cyc(input bit wr, input int wp, input int d,
                     input bit rd, input int rp, input bit clr);
    bit   allow;
    bit   commit;
    bit   drop;
    bit   cons;
    exp_t e;
    bus.WRITE_I     = wr;
    bus.WRITE_PTR_I = AW'(wp);
    bus.DMEM_I      = W'(d);
    bus.READ_I      = rd;
    bus.READ_PTR_I  = AW'(rp);
    bus.CLEAR_I     = clr;
    bus.MODE_I      = cur_md;
    allow  = (cur_md == TRB_MODE_TRACE) || (m_fill < DEPTH);
    commit = m_turn && wr && allow;
    drop   = m_turn && wr && !allow;
    cons   = rd && (m_fill != 0);
    if (!m_turn) begin
      m_dmem = m_mem[rp];
      m_dkn  = m_kn[rp];
    end
    if (commit) begin
      m_mem[wp] = d;
      m_kn[wp]  = 1'b1;
    end
    if (clr) m_fill = 0;
    else if (commit && !cons) m_fill = (m_fill < DEPTH) ? m_fill + 1 : DEPTH;
    else if (cons && !commit) m_fill = m_fill - 1;
`ifdef TRB_MEM_OVF_CNT_EN
    if (clr) m_ovf = 0;
    else if (drop && m_ovf < OVF_MAX) m_ovf = m_ovf + 1;
`else
    if (drop) m_ovf = 0;
`endif
    m_turn   = !m_turn;
    e.turn   = m_turn;
    e.fill   = m_fill;
    e.rallow = (m_fill != 0);
    e.wallow = (cur_md == TRB_MODE_TRACE) || (m_fill < DEPTH);
    e.dmem   = m_dmem;
    e.dknown = m_dkn;
    e.ovf    = m_ovf;
    sbq.push_back(e);
    @(negedge CLK_I);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr_cmt(input int wp, input int d);
    if (!m_turn) idle(1);
    cyc(1, wp, d, 0, 0, 0);
  endtask

  task automatic rd_at(input int rp);
    if (m_turn) idle(1);
    cyc(0, 0, 0, 0, rp, 0);
  endtask

  task automatic clear();
    cyc(0, 0, 0, 0, 0, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_turn"},   32'(bus.RW_TURN_O),     32'd0);
    chk({tag, "_fill"},   32'(bus.FILL_O),        32'd0);
    chk({tag, "_rallow"}, 32'(bus.READ_ALLOW_O),  32'd0);
    chk({tag, "_wallow"}, 32'(bus.WRITE_ALLOW_O), 32'd1);
    chk({tag, "_dmem"},   32'(bus.DMEM_O),        32'd0);
    chk({tag, "_ovf"},    32'(bus.OVF_CNT_O),     32'd0);
  endtask

  // Monitor: one scoreboard entry per clock while enabled.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK_I);
      #1;
      if (mon_en) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("sb_turn",   32'(bus.RW_TURN_O),     32'(e.turn));
          chk("sb_fill",   32'(bus.FILL_O),        32'(e.fill));
          chk("sb_rallow", 32'(bus.READ_ALLOW_O),  32'(e.rallow));
          chk("sb_wallow", 32'(bus.WRITE_ALLOW_O), 32'(e.wallow));
          chk("sb_ovf",    32'(bus.OVF_CNT_O),     32'(e.ovf));
          if (e.dknown) chk("sb_dmem", 32'(bus.DMEM_O), 32'(e.dmem));
        end
      end
    end
  end

  initial begin
    int exp_ovf;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 0;
      m_kn[i]  = 1'b0;
    end
    bus.WRITE_I     = 1'b0;
    bus.WRITE_PTR_I = '0;
    bus.DMEM_I      = '0;
    bus.READ_I      = 1'b0;
    bus.READ_PTR_I  = '0;
    bus.CLEAR_I     = 1'b0;
    bus.MODE_I      = TRB_MODE_TRACE;
    model_reset();

    // Reset held for three cycles.
    repeat (3) begin
      @(negedge CLK_I);
      chk_reset_vals("rst");
    end
    RST_I  = 1'b0;
    mon_en = 1'b1;

    // Turn pattern on idle cycles.
    idle(4);

    // Write 0xA5 at 2, read back.
    wr_cmt(2, 'hA5);
    rd_at(2);
    chk("wr_rd_dmem",   32'(bus.DMEM_O),       32'hA5);
    chk("wr_rd_fill",   32'(bus.FILL_O),       32'd1);
    chk("wr_rd_rallow", 32'(bus.READ_ALLOW_O), 32'd1);

    // Stream full, then a refused 9th write.
    clear();
    cur_md = TRB_MODE_STREAM;
    for (int i = 0; i < DEPTH; i++) wr_cmt(i, 'h10 + i);
    chk("stream_fill",   32'(bus.FILL_O),        32'd8);
    chk("stream_wallow", 32'(bus.WRITE_ALLOW_O), 32'd0);
    wr_cmt(3, 'hEE);
`ifdef TRB_MEM_OVF_CNT_EN
    exp_ovf = 1;
`else
    exp_ovf = 0;
`endif
    chk("stream_ovf", 32'(bus.OVF_CNT_O), 32'(exp_ovf));
    rd_at(3);
    chk("stream_keep", 32'(bus.DMEM_O), 32'h13);

    // Trace overwrite with 10 writes.
    clear();
    cur_md = TRB_MODE_TRACE;
    for (int i = 0; i < 10; i++) wr_cmt(i % DEPTH, 'h40 + i);
    chk("trace_fill",   32'(bus.FILL_O),        32'd8);
    chk("trace_wallow", 32'(bus.WRITE_ALLOW_O), 32'd1);
    chk("trace_ovf",    32'(bus.OVF_CNT_O),     32'd0);
    rd_at(0);
    chk("trace_newest", 32'(bus.DMEM_O), 32'h48);

    // Commit and consume together at fill 4.
    clear();
    for (int i = 0; i < 4; i++) wr_cmt(i, 'h20 + i);
    if (!m_turn) idle(1);
    cyc(1, 5, 'h55, 1, 0, 0);
    chk("simul_fill", 32'(bus.FILL_O), 32'd4);
    clear();
    cyc(0, 0, 0, 1, 0, 0);
    chk("empty_rd_fill", 32'(bus.FILL_O), 32'd0);

    // Clear beats a simultaneous commit; turn keeps its phase.
    for (int i = 0; i < 5; i++) wr_cmt(i, 'h30 + i);
    if (!m_turn) idle(1);
    cyc(1, 6, 'h66, 0, 0, 1);
    chk("clr_fill",   32'(bus.FILL_O),       32'd0);
    chk("clr_rallow", 32'(bus.READ_ALLOW_O), 32'd0);
    chk("clr_turn0",  32'(bus.RW_TURN_O),    32'd0);
    idle(1);
    chk("clr_turn1",  32'(bus.RW_TURN_O),    32'd1);

    // Asynchronous reset in the middle of traffic.
    wr_cmt(7, 'h77);
    mon_en = 1'b0;
    #2 RST_I = 1'b1;
    #1 chk_reset_vals("midrst");
    @(negedge CLK_I);
    @(negedge CLK_I);
    RST_I = 1'b0;
    model_reset();
    mon_en = 1'b1;
    rd_at(7);
    chk("midrst_ram_kept", 32'(bus.DMEM_O), 32'h77);

    // Randomised traffic.
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(63) == 0)
        cur_md = (cur_md == TRB_MODE_TRACE) ? TRB_MODE_STREAM : TRB_MODE_TRACE;
      cyc(($urandom_range(9) < 6), int'($urandom_range(DEPTH - 1)), int'($urandom_range(255)),
          ($urandom_range(9) < 4), int'($urandom_range(DEPTH - 1)),
          ($urandom_range(49) == 0));
    end

    idle(2);
    mon_en = 1'b0;
    chk("sb_leftover", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
